// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// The FSM state type and the grant identifiers are used by the top and by the starvation guard.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/arb_starve_guard.sv
// Picks the winner of an IDLE-cycle arbitration. Data normally wins; fetch is forced
// through once data has won STARVE_MAX grants in a row while fetch was waiting.
module arb_starve_guard
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic i_req,
  input  logic d_req,
  output logic gnt_d
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          guard_fire;

  assign guard_fire = i_req && (STARVE_MAX != 0) && (streak_q == SMAX);
  assign gnt_d      = (d_req && !guard_fire) ? GNT_D : GNT_I;

  // Streak counts data wins that kept a pending fetch waiting; any other grant clears it.
  always_comb begin
    streak_d = streak_q;
    if (sample) begin
      if ((gnt_d == GNT_D) && i_req) begin
        if (streak_q != SMAX) begin
          streak_d = streak_q + SW'(1);
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one synchronous single-port RAM
// with a fixed read latency; every output is driven straight from a register.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT - 1);

  arb_state_e    state_q;
  logic          winner_q;
  logic [LW-1:0] lat_cnt_q;
  logic          i_ack_q, i_rvalid_q, d_ack_q, d_rvalid_q;
  logic [DW-1:0] i_rdata_q, d_rdata_q;
  logic          ram_en_q, ram_we_q, busy_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;
  logic          sample;
  logic          gnt_d;

  assign sample = (state_q == IDLE) && (i_req || d_req);

  arb_starve_guard #(
    .STARVE_MAX(STARVE_MAX)
  ) u_guard (
    .clk   (clk),
    .rst   (rst),
    .sample(sample),
    .i_req (i_req),
    .d_req (d_req),
    .gnt_d (gnt_d)
  );

  // Pulses default low every cycle; ram_we stays valid through ISSUE so it can steer the write path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      winner_q    <= GNT_I;
      lat_cnt_q   <= '0;
      i_ack_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            winner_q    <= gnt_d;
            ram_en_q    <= 1'b1;
            ram_we_q    <= (gnt_d == GNT_D) && d_we;
            ram_addr_q  <= (gnt_d == GNT_D) ? d_addr : i_addr;
            ram_wdata_q <= (gnt_d == GNT_D) ? d_wdata : '0;
            i_ack_q     <= (gnt_d == GNT_I);
            d_ack_q     <= (gnt_d == GNT_D);
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (ram_we_q) begin
            d_rdata_q  <= '0;
            d_rvalid_q <= 1'b1;
            state_q    <= RESP;
          end else begin
            lat_cnt_q <= LAT_INIT;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_q == '0) begin
            if (winner_q == GNT_D) begin
              d_rdata_q  <= ram_rdata;
              d_rvalid_q <= 1'b1;
            end else begin
              i_rdata_q  <= ram_rdata;
              i_rvalid_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - LW'(1);
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: dutA (RD_LAT=1, STARVE_MAX=4) and dutB (RD_LAT=3, STARVE_MAX=0),
// each with its own RAM model; only the selected DUT sees requests.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        iReq, dReq, dWe;
  logic [31:0] iAddr, dAddr, dWdata;
  logic        iReqA, dReqA, iReqB, dReqB;
  logic        preEn;
  logic [31:0] preAddr, preData;

  logic        aIAck, aIRvalid, aDAck, aDRvalid, aRamEn, aRamWe, aBusy;
  logic [31:0] aIRdata, aDRdata, aRamAddr, aRamWdata, aRamRdata;
  logic        bIAck, bIRvalid, bDAck, bDRvalid, bRamEn, bRamWe, bBusy;
  logic [31:0] bIRdata, bDRdata, bRamAddr, bRamWdata, bRamRdata;

  logic        oIAck, oIRvalid, oDAck, oDRvalid, oRamEn, oRamWe, oBusy;
  logic [31:0] oIRdata, oDRdata, oRamAddr, oRamWdata;

  int checks = 0;
  int errors = 0;

  assign iReqA = iReq & ~sel;
  assign dReqA = dReq & ~sel;
  assign iReqB = iReq & sel;
  assign dReqB = dReq & sel;

  assign oIAck     = sel ? bIAck     : aIAck;
  assign oIRvalid  = sel ? bIRvalid  : aIRvalid;
  assign oIRdata   = sel ? bIRdata   : aIRdata;
  assign oDAck     = sel ? bDAck     : aDAck;
  assign oDRvalid  = sel ? bDRvalid  : aDRvalid;
  assign oDRdata   = sel ? bDRdata   : aDRdata;
  assign oRamEn    = sel ? bRamEn    : aRamEn;
  assign oRamWe    = sel ? bRamWe    : aRamWe;
  assign oRamAddr  = sel ? bRamAddr  : aRamAddr;
  assign oRamWdata = sel ? bRamWdata : aRamWdata;
  assign oBusy     = sel ? bBusy     : aBusy;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .STARVE_MAX(4)) dutA (
    .clk(clk), .rst(rst),
    .i_req(iReqA), .i_addr(iAddr), .i_ack(aIAck), .i_rvalid(aIRvalid), .i_rdata(aIRdata),
    .d_req(dReqA), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_ack(aDAck), .d_rvalid(aDRvalid), .d_rdata(aDRdata),
    .ram_en(aRamEn), .ram_we(aRamWe), .ram_addr(aRamAddr), .ram_wdata(aRamWdata),
    .ram_rdata(aRamRdata), .busy(aBusy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .STARVE_MAX(0)) dutB (
    .clk(clk), .rst(rst),
    .i_req(iReqB), .i_addr(iAddr), .i_ack(bIAck), .i_rvalid(bIRvalid), .i_rdata(bIRdata),
    .d_req(dReqB), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_ack(bDAck), .d_rvalid(bDRvalid), .d_rdata(bDRdata),
    .ram_en(bRamEn), .ram_we(bRamWe), .ram_addr(bRamAddr), .ram_wdata(bRamWdata),
    .ram_rdata(bRamRdata), .busy(bBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: read data appears RD_LAT cycles after ram_en; idle slots return a poison word.
  logic [31:0] memA [0:255];
  logic [31:0] memB [0:255];
  logic [31:0] pipeA;
  logic [31:0] pipeB [0:2];

  always @(posedge clk) begin
    if (preEn) memA[preAddr[9:2]] <= preData;
    else if (aRamEn && aRamWe) memA[aRamAddr[9:2]] <= aRamWdata;
    pipeA <= (aRamEn && !aRamWe) ? memA[aRamAddr[9:2]] : 32'h0BAD0BAD;
  end
  assign aRamRdata = pipeA;

  always @(posedge clk) begin
    if (preEn) memB[preAddr[9:2]] <= preData;
    else if (bRamEn && bRamWe) memB[bRamAddr[9:2]] <= bRamWdata;
    pipeB[0] <= (bRamEn && !bRamWe) ? memB[bRamAddr[9:2]] : 32'h0BAD0BAD;
    pipeB[1] <= pipeB[0];
    pipeB[2] <= pipeB[1];
  end
  assign bRamRdata = pipeB[2];

  typedef struct {
    logic        isData;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {25'd0, oIAck, oIRvalid, oDAck, oDRvalid, oRamEn, oRamWe, oBusy}, 32'd0);
    checkOutput({tag, "_irdata"}, oIRdata, 32'd0);
    checkOutput({tag, "_drdata"}, oDRdata, 32'd0);
    checkOutput({tag, "_ramaddr"}, oRamAddr, 32'd0);
    checkOutput({tag, "_ramwdata"}, oRamWdata, 32'd0);
  endtask

  task automatic resetAll();
    iReq = 1'b0;
    dReq = 1'b0;
    dWe  = 1'b0;
    rst  = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // One isolated transaction, checked cycle by cycle from the ack to the return to IDLE.
  task automatic applyStimulus(input logic isData, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input int lat, input string tag);
    int n;
    if (isData) begin
      dReq = 1'b1; dWe = we; dAddr = addr; dWdata = wdata;
    end else begin
      iReq = 1'b1; iAddr = addr;
    end
    tick();
    checkOutput({tag, "_ack"}, {31'd0, isData ? oDAck : oIAck}, 32'd1);
    checkOutput({tag, "_otherack"}, {31'd0, isData ? oIAck : oDAck}, 32'd0);
    checkOutput({tag, "_ramen"}, {31'd0, oRamEn}, 32'd1);
    checkOutput({tag, "_ramwe"}, {31'd0, oRamWe}, {31'd0, isData & we});
    checkOutput({tag, "_ramaddr"}, oRamAddr, addr);
    if (isData && we) checkOutput({tag, "_ramwdata"}, oRamWdata, wdata);
    iReq = 1'b0;
    dReq = 1'b0;
    n = (isData && we) ? 1 : lat + 1;
    for (int k = 1; k < n; k++) begin
      tick();
      checkOutput($sformatf("%s_early%0d", tag, k), {30'd0, oIRvalid, oDRvalid}, 32'd0);
    end
    tick();
    checkOutput({tag, "_rvalid"}, {30'd0, oIRvalid, oDRvalid}, isData ? 32'd1 : 32'd2);
    checkOutput({tag, "_rdata"}, isData ? oDRdata : oIRdata, expRdata);
    tick();
    checkOutput({tag, "_idle"}, {30'd0, oBusy, oIRvalid | oDRvalid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dAcks, iGrants, rvCount;
    int gap [2];
    sel = 1'b0; preEn = 1'b0; preAddr = '0; preData = '0;
    iAddr = '0; dAddr = '0; dWdata = '0;
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    rst = 1'b1;
    $display("[TB] start");

    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'h8C020004};
    vecs[1] = '{1'b1, 1'b1, 32'h040, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h040, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'h044, 32'h12345678, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h044, 32'h0,        32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h8C020004};

    tick();
    preEn = 1'b1; preAddr = 32'h100; preData = 32'h8C020004;
    tick();
    preEn = 1'b0;
    checkAllZero("resetA");
    sel = 1'b1;
    checkAllZero("resetB");
    sel = 1'b0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].isData, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].expRdata, 1, $sformatf("vec%0d", i));
    end

    // Collision: data wins, fetch waits for the next IDLE.
    iAddr = 32'h100; iReq = 1'b1;
    dAddr = 32'h040; dWe = 1'b0; dReq = 1'b1;
    tick();
    checkOutput("coll_dack", {30'd0, oDAck, oIAck}, 32'd2);
    dReq = 1'b0;
    tick();
    checkOutput("coll_r2_iack", {31'd0, oIAck}, 32'd0);
    tick();
    checkOutput("coll_drvalid", {31'd0, oDRvalid}, 32'd1);
    checkOutput("coll_drdata", oDRdata, 32'hDEADBEEF);
    checkOutput("coll_r3_iack", {31'd0, oIAck}, 32'd0);
    tick();
    checkOutput("coll_r4_iack", {31'd0, oIAck}, 32'd0);
    tick();
    checkOutput("coll_iack", {31'd0, oIAck}, 32'd1);
    checkOutput("coll_iaddr", oRamAddr, 32'h100);
    iReq = 1'b0;
    tick();
    tick();
    checkOutput("coll_irvalid", {31'd0, oIRvalid}, 32'd1);
    checkOutput("coll_irdata", oIRdata, 32'h8C020004);
    repeat (2) tick();

    // Starvation guard: both held; expect 4 data grants between fetch grants.
    iAddr = 32'h100; iReq = 1'b1;
    dAddr = 32'h080; dWe = 1'b1; dWdata = 32'h5555AAAA; dReq = 1'b1;
    dAcks = 0; iGrants = 0; gap[0] = 0; gap[1] = 0;
    for (int c = 0; c < 80 && iGrants < 2; c++) begin
      tick();
      if (oDAck) dAcks++;
      if (oIAck) begin
        checkOutput("starve_i_ramwe", {31'd0, oRamWe}, 32'd0);
        gap[iGrants] = dAcks;
        iGrants++;
        dAcks = 0;
      end
    end
    iReq = 1'b0;
    dReq = 1'b0;
    checkOutput("starve_igrants", 32'(iGrants), 32'd2);
    checkOutput("starve_gap0", 32'(gap[0]), 32'd4);
    checkOutput("starve_gap1", 32'(gap[1]), 32'd4);
    repeat (8) tick();
    checkOutput("starve_idle", {31'd0, oBusy}, 32'd0);

    // dutB: RD_LAT=3 latency and busy window.
    resetAll();
    sel = 1'b1;
    iAddr = 32'h100; iReq = 1'b1;
    checkOutput("lat_busyR", {31'd0, oBusy}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        checkOutput("lat_iack", {31'd0, oIAck}, 32'd1);
        iReq = 1'b0;
      end
      checkOutput($sformatf("lat_busy%0d", k), {31'd0, oBusy}, 32'd1);
      checkOutput($sformatf("lat_rvalid%0d", k), {31'd0, oIRvalid}, (k == 5) ? 32'd1 : 32'd0);
    end
    checkOutput("lat_irdata", oIRdata, 32'h8C020004);
    tick();
    checkOutput("lat_busy6", {31'd0, oBusy}, 32'd0);
    tick();

    // dutB: guard disabled, fetch only gets in once data stops asking.
    iAddr = 32'h100; iReq = 1'b1;
    dAddr = 32'h080; dWe = 1'b1; dWdata = 32'h0F0F0F0F; dReq = 1'b1;
    dAcks = 0; iGrants = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (oDAck) dAcks++;
      if (oIAck) iGrants++;
    end
    checkOutput("nostarve_dacks", 32'(dAcks), 32'd10);
    checkOutput("nostarve_iacks", 32'(iGrants), 32'd0);
    dReq = 1'b0;
    tick();
    checkOutput("nostarve_iack", {31'd0, oIAck}, 32'd1);
    iReq = 1'b0;
    repeat (8) tick();

    // dutB: asynchronous reset while WAITing discards the access.
    iAddr = 32'h100; iReq = 1'b1;
    tick();
    iReq = 1'b0;
    tick();
    checkOutput("rstmid_busy_before", {31'd0, oBusy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkAllZero("rstmid");
    tick();
    rst = 1'b0;
    rvCount = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (oIRvalid || oDRvalid) rvCount++;
    end
    checkOutput("rstmid_norvalid", 32'(rvCount), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 32'h8C020004, 3, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
